// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;
   localparam int unsigned OP_ACC_BIT = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_e;

   typedef enum logic {
      MODE_MUL,
      MODE_DIV
   } mode_e;

endpackage

// File: rtl/muldiv_if.sv
// Command/result bundle between the core controller and the multiply/divide unit.
interface muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             wr_hi;
   logic             wr_lo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, wr_hi, wr_lo, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, wr_hi, wr_lo, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide over a 2*WIDTH partial.
// Divide mode leaves bit 0 clear; the new quotient bit is returned on q_o.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  mode_e              mode_i,
   input  logic [2*WIDTH-1:0] part_i,
   input  logic [WIDTH-1:0]   opnd_i,
   output logic [2*WIDTH-1:0] part_o,
   output logic               q_o
);
   logic [WIDTH:0] sum;
   logic [WIDTH:0] rsh;
   logic [WIDTH:0] diff;

   always_comb begin
      sum    = {1'b0, part_i[2*WIDTH-1:WIDTH]} + (part_i[0] ? {1'b0, opnd_i} : '0);
      rsh    = {part_i[2*WIDTH-1:WIDTH], part_i[WIDTH-1]};
      diff   = rsh - {1'b0, opnd_i};
      q_o    = 1'b0;
      part_o = '0;
      if (mode_i == MODE_MUL) begin
         part_o = {sum, part_i[WIDTH-1:1]};
      end else begin
         // No borrow out of the trial subtraction means the divisor fits.
         q_o    = ~diff[WIDTH];
         part_o = {(q_o ? diff[WIDTH-1:0] : rsh[WIDTH-1:0]), part_i[WIDTH-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MULDIV_ACC_EN to enable MADD/MADDU accumulate on op[2].
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned PW    = 2 * WIDTH;

   state_e             state_q, state_d;
   mode_e              mode_q, mode_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]      part_q, part_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   araw_q, araw_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
   logic               dz_q, dz_d;
   logic               busy_q, busy_d, done_q, done_d;
`ifdef MULDIV_ACC_EN
   logic               acc_q, acc_d;
`else
   logic               unused_op_acc;
   assign unused_op_acc = bus.op[OP_ACC_BIT];
`endif

   logic               sa, sb, signed_op;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [PW-1:0]      res;
   logic [PW-1:0]      step_part;
   logic               step_q;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode_i (mode_q),
      .part_i (part_q),
      .opnd_i (opnd_q),
      .part_o (step_part),
      .q_o    (step_q)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         mode_q   <= MODE_MUL;
         cnt_q    <= '0;
         part_q   <= '0;
         opnd_q   <= '0;
         araw_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef MULDIV_ACC_EN
         acc_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         part_q   <= part_d;
         opnd_q   <= opnd_d;
         araw_q   <= araw_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         dz_q     <= dz_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef MULDIV_ACC_EN
         acc_q    <= acc_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      part_d    = part_q;
      opnd_d    = opnd_q;
      araw_d    = araw_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      neg_lo_d  = neg_lo_q;
      neg_hi_d  = neg_hi_q;
      dz_d      = dz_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
`ifdef MULDIV_ACC_EN
      acc_d     = acc_q;
`endif
      signed_op = bus.op[0];
      sa        = signed_op & bus.a[WIDTH-1];
      sb        = signed_op & bus.b[WIDTH-1];
      abs_a     = sa ? WIDTH'(-bus.a) : bus.a;
      abs_b     = sb ? WIDTH'(-bus.b) : bus.b;
      res       = '0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.wr_hi) hi_d = bus.wdata;
            if (bus.wr_lo) lo_d = bus.wdata;
            if (bus.start) begin
               mode_d   = bus.op[1] ? MODE_DIV : MODE_MUL;
               part_d   = {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
               opnd_d   = bus.op[1] ? abs_b : abs_a;
               araw_d   = bus.a;
               neg_lo_d = sa ^ sb;
               neg_hi_d = sa;
               dz_d     = (bus.b == '0);
               cnt_d    = CNT_W'(WIDTH);
               busy_d   = 1'b1;
               state_d  = S_CALC;
`ifdef MULDIV_ACC_EN
               acc_d    = bus.op[OP_ACC_BIT] & ~bus.op[1];
`endif
            end
         end
         S_CALC: begin
            part_d = step_part | PW'(step_q);
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (mode_q == MODE_DIV) begin
               // Division by zero bypasses sign correction entirely.
               if (dz_q) begin
                  hi_d = araw_q;
                  lo_d = '1;
               end else begin
                  lo_d = neg_lo_q ? -part_q[WIDTH-1:0] : part_q[WIDTH-1:0];
                  hi_d = neg_hi_q ? -part_q[PW-1:WIDTH] : part_q[PW-1:WIDTH];
               end
            end else begin
               res = neg_lo_q ? -part_q : part_q;
`ifdef MULDIV_ACC_EN
               if (acc_q) res = res + {hi_q, lo_q};
`endif
               {hi_d, lo_d} = res;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int unsigned W   = 32;
   localparam int unsigned LAT = W + 1;
`ifdef MULDIV_ACC_EN
   localparam bit ACC = 1'b1;
`else
   localparam bit ACC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   muldiv_if #(.WIDTH(W)) bus();
   muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int   n_checks = 0;
   int   n_errors = 0;
   logic chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result of one operation from plain arithmetic.
   function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] hilo);
      logic [63:0] r;
      int          sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      r  = '0;
      case (o[1:0])
         OP_MULTU: r = {32'b0, x} * {32'b0, y};
         OP_MULT:  r = 64'(longint'(sx) * longint'(sy));
         OP_DIVU:  r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
         OP_DIV: begin
            if (y == 0)                                  r = {x, 32'hFFFF_FFFF};
            else if (x == 32'h8000_0000 && y == '1)      r = {32'h0, 32'h8000_0000};
            else                                         r = {32'(sx % sy), 32'(sx / sy)};
         end
         default: r = '0;
      endcase
      if (ACC && o[2] && !o[1]) r = r + hilo;
      return r;
   endfunction

   int unsigned m_cnt;
   logic        m_done;
   logic [31:0] m_hi, m_lo, m_nh, m_nl;
   logic [63:0] m_res;
   assign m_nh = bus.wr_hi ? bus.wdata : m_hi;
   assign m_nl = bus.wr_lo ? bus.wdata : m_lo;

   always @(posedge clk) begin
      if (!rst) begin
         m_cnt <= 0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_res <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; m_done <= 1'b1;
            end
         end else begin
            m_hi <= m_nh;
            m_lo <= m_nl;
            if (bus.start) begin
               m_res <= model_res(bus.op, bus.a, bus.b, {m_nh, m_nl});
               m_cnt <= LAT;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(bus.busy), 32'(m_cnt != 0));
         check("done", 32'(bus.done), 32'(m_done));
         check("hi", bus.hi, m_hi);
         check("lo", bus.lo, m_lo);
      end
   end

   task automatic idle_in();
      bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge right after the start edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
      @(negedge clk);
      idle_in();
      bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
   endtask

   // mode 0: quiet, 1: random noise while busy, 2: scripted start at 5 and wr_lo at 10.
   task automatic wait_done(input int mode, output int j);
      j = 0;
      while (bus.done !== 1'b1 && j < 200) begin
         idle_in();
         if (mode == 1 && j < int'(W) - 1) begin
            bus.start = 1'($urandom); bus.wr_hi = 1'($urandom); bus.wr_lo = 1'($urandom);
            bus.wdata = $urandom; bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
         end else if (mode == 2 && j == 5) begin
            bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd3;
         end else if (mode == 2 && j == 10) begin
            bus.wr_lo = 1'b1; bus.wdata = 32'h1234;
         end
         @(negedge clk);
         j++;
      end
      idle_in();
      if (bus.done !== 1'b1) begin
         n_checks++; n_errors++;
         $display("FAIL done_timeout: got no done expected done within 200 cycles");
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         4:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      bit  seen;
      rst = 1'b0;
      idle_in();
      bus.op = '0; bus.a = '0; bus.b = '0; bus.wdata = '0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      check("rst_hi", bus.hi, 32'h0);
      check("rst_lo", bus.lo, 32'h0);
      rst = 1'b1;
      @(negedge clk);

      issue({1'b0, OP_MULTU}, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(0, lat);
      check("multu_lat", 32'(lat), 32'd33);
      check("multu_hi", bus.hi, 32'hFFFF_FFFE);
      check("multu_lo", bus.lo, 32'h0000_0001);

      @(negedge clk);
      issue({1'b0, OP_MULT}, 32'hFFFF_FFFD, 32'd5);
      wait_done(0, lat);
      check("mult_hi", bus.hi, 32'hFFFF_FFFF);
      check("mult_lo", bus.lo, 32'hFFFF_FFF1);
      issue({1'b0, OP_DIV}, 32'hFFFF_FFF9, 32'd2);    // accepted in the done cycle
      wait_done(0, lat);
      check("b2b_lat", 32'(lat), 32'd33);
      check("div_lo", bus.lo, 32'hFFFF_FFFD);
      check("div_hi", bus.hi, 32'hFFFF_FFFF);

      issue({1'b0, OP_DIVU}, 32'd100, 32'd0);
      wait_done(0, lat);
      check("divz_lo", bus.lo, 32'hFFFF_FFFF);
      check("divz_hi", bus.hi, 32'h0000_0064);
      issue({1'b0, OP_DIV}, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(0, lat);
      check("ovf_lo", bus.lo, 32'h8000_0000);
      check("ovf_hi", bus.hi, 32'h0);

      @(negedge clk);
      issue({1'b0, OP_MULTU}, 32'd7, 32'd9);
      wait_done(2, lat);
      check("ign_hi", bus.hi, 32'h0);
      check("ign_lo", bus.lo, 32'd63);
      bus.wr_lo = 1'b1; bus.wdata = 32'h1234;
      @(negedge clk);
      idle_in();
      check("mtlo_lo", bus.lo, 32'h1234);

      @(negedge clk);
      issue({1'b0, OP_DIVU}, 32'd1000, 32'd7);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'h0);
      check("abort_done", 32'(bus.done), 32'h0);
      check("abort_hi", bus.hi, 32'h0);
      check("abort_lo", bus.lo, 32'h0);
      rst = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      check("abort_no_done", 32'(seen), 32'h0);

      bus.wr_hi = 1'b1; bus.wdata = 32'h0;
      @(negedge clk);
      bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      idle_in();
      issue({1'b1, OP_MULTU}, 32'd1, 32'd1);
      wait_done(0, lat);
      check("acc_hi", bus.hi, ACC ? 32'h1 : 32'h0);
      check("acc_lo", bus.lo, ACC ? 32'h0 : 32'h1);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            repeat ($urandom_range(1, 3)) begin
               @(negedge clk);
               bus.wr_hi = 1'($urandom); bus.wr_lo = 1'($urandom); bus.wdata = $urandom;
            end
         end
         bus.wr_hi = ($urandom_range(0, 3) == 0);
         bus.wr_lo = ($urandom_range(0, 3) == 0);
         bus.wdata = pick();
         issue(3'($urandom), pick(), pick());
         wait_done(1, lat);
         check("rand_lat", 32'(lat), 32'(LAT));
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
